// File: rtl/ila_readout.sv
// ila_readout: dumps ila_core's capture buffer as a count header
// followed by every sample, least significant slice first.
module ila_readout #(
  parameter  int DATA_W   = 32,
  parameter  int BUFFER_W = 8,
  parameter  int SIGNAL_W = 8,
  parameter  int READ_LAT = 0,
  localparam int N_WORDS  = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [BUFFER_W-1:0] samples,
  output logic [BUFFER_W-1:0] index,
  output logic [SEL_W-1:0]    value_select,
  input  logic [DATA_W-1:0]   value,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    WAIT,
    PUSH
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_WORDS - 1);
  localparam logic [2:0]       LAT      = 3'(READ_LAT);

  state_t              state_q, state_d;
  logic [BUFFER_W-1:0] n_q, n_d;
  logic [BUFFER_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                abt_q, abt_d;
  logic                hs;
  logic                last_word;

  assign hs        = m_valid && m_ready;
  assign last_word = (idx_q == n_q - BUFFER_W'(1))
                  && (sel_q == SEL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = samples;
          idx_d   = '0;
          sel_d   = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (hs) begin
          cnt_d = '0;
          if (n_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          data_d  = value;
          state_d = PUSH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      PUSH: begin
        if (hs) begin
          cnt_d = '0;
          if (last_word) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (sel_q != SEL_LAST) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = WAIT;
          end else begin
            sel_d   = '0;
            idx_d   = idx_q + BUFFER_W'(1);
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a coincident final handshake
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      abt_d   = 1'b1;
    end
  end

  assign index        = idx_q;
  assign value_select = sel_q;
  assign busy         = state_q != IDLE;
  assign m_valid      = (state_q == HEADER) || (state_q == PUSH);
  assign m_data       = (state_q == HEADER) ? DATA_W'(n_q)
                      : (state_q == PUSH)   ? data_q
                      : '0;
  assign m_last       = ((state_q == HEADER) && (n_q == '0))
                     || ((state_q == PUSH) && last_word);
  assign done         = done_q;
  assign aborted      = abt_q;

endmodule

// File: tb/tb_ila_readout.sv
// Bench for ila_readout: two-slice samples, two-cycle read latency,
// expected stream built from a sample memory model.
module tb_ila_readout;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int SW = 64;
  localparam int RL = 2;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [BW-1:0] samples = '0;
  logic [BW-1:0] index;
  logic [0:0]    value_select;
  logic [DW-1:0] value;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, busy, done, aborted;

  logic [SW-1:0] mem [256];
  logic [BW-1:0] idx_h1, idx_h2;
  logic          sel_h1, sel_h2;

  int tests = 0;
  int fails = 0;

  ila_readout #(
    .DATA_W(DW), .BUFFER_W(BW), .SIGNAL_W(SW), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .samples(samples), .index(index), .value_select(value_select),
    .value(value), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // ila_core read port: data reflects the address RL cycles ago
  always_ff @(posedge clk) begin
    idx_h1 <= index;
    idx_h2 <= idx_h1;
    sel_h1 <= value_select[0];
    sel_h2 <= sel_h1;
  end
  assign value = sel_h2 ? mem[idx_h2][63:32] : mem[idx_h2][31:0];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input int n, input bit rnd,
                          input int abort_hs, input bit poke);
    logic [DW-1:0] q_d[$];
    bit            q_l[$];
    int            q_i[$];
    int            q_s[$];
    int            hs = 0;
    int            gap = 0;
    int            cyc = 0;
    int            total;
    bit            pv = 0;
    bit            pl = 0;
    bit            fin = 0;
    logic [DW-1:0] pd = '0;
    q_d.push_back(DW'(n));
    q_l.push_back(n == 0);
    q_i.push_back(-1);
    q_s.push_back(-1);
    for (int k = 0; k < n; k++)
      for (int s = 0; s < NW; s++) begin
        q_d.push_back(mem[k][s*DW +: DW]);
        q_l.push_back(k == n - 1 && s == NW - 1);
        q_i.push_back(k);
        q_s.push_back(s);
      end
    total = q_d.size();
    samples = BW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);
    while (!fin && cyc < 3000) begin
      samples = BW'($urandom);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv) begin
        chk("hold_v", m_valid, 1);
        chk("hold_d", m_data, pd);
        chk("hold_l", m_last, pl);
      end
      if (n == 0) chk("idx_still", index, 0);
      if (m_valid && m_ready) begin
        if (hs + 1 == abort_hs) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("ab_pulse", aborted, 1);
          chk("ab_busy", busy, 0);
          chk("ab_valid", m_valid, 0);
          chk("ab_done", done, 0);
          @(negedge clk);
          chk("ab_clear", aborted, 0);
          chk("ab_done2", done, 0);
          return;
        end
        if (q_d.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk("data", m_data, q_d.pop_front());
          chk("last", m_last, q_l.pop_front());
          if (q_i[0] >= 0) begin
            chk("index", index, q_i[0]);
            chk("vsel", value_select, q_s[0]);
          end
          void'(q_i.pop_front());
          void'(q_s.pop_front());
        end
        if (!rnd && hs > 0) chk("gap", gap, RL + 1);
        hs++;
        gap = 0;
        if (hs == total) fin = 1;
      end else if (!m_valid) begin
        gap++;
      end
      pv = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      start = poke && hs == 2;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!fin) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("done", done, 1);
    chk("busy_off", busy, 0);
    chk("valid_off", m_valid, 0);
    chk("no_abort", aborted, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = {32'(k + 1), 32'(k)};
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", index, 0);
    chk("rst_abort", aborted, 0);
    rst = 1'b0;
    @(negedge clk);

    run_dump(2, 0, 0, 0);
    run_dump(0, 0, 0, 0);
    for (int k = 0; k < 256; k++) mem[k] = {$urandom, $urandom};
    run_dump(5, 1, 0, 1);
    run_dump(5, 0, 4, 0);
    run_dump(5, 0, 0, 0);
    run_dump(3, 0, 7, 0);
    for (int i = 0; i < 3; i++)
      run_dump($urandom_range(1, 20), 1, 0, 0);
    run_dump(255, 0, 0, 0);

    samples = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("push_valid", m_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_index", index, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_abort", aborted, 0);
    chk("arst_done2", done, 0);
    run_dump(4, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
